// File: rtl/wb_arbiter_2m.sv
//------------------------------------------------------------------------------
// wb_arbiter_2m : two-master Wishbone classic arbiter with alternating
//                 priority, whole-cycle ownership and a stalled-slave timeout.
// Revision 1.0
//------------------------------------------------------------------------------
`default_nettype none

module wb_arbiter_2m #(
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_WIDTH     = 32,
  parameter int SELECT_WIDTH   = 4,
  parameter int TIMEOUT_CYCLES = 1023
) (
  input  logic                    wb_clk,
  input  logic                    wb_rst_n,
  // master 0
  input  logic                    m0_cyc_i,
  input  logic                    m0_stb_i,
  input  logic                    m0_we_i,
  input  logic [ADDR_WIDTH-1:0]   m0_adr_i,
  input  logic [DATA_WIDTH-1:0]   m0_dat_i,
  input  logic [SELECT_WIDTH-1:0] m0_sel_i,
  output logic [DATA_WIDTH-1:0]   m0_dat_o,
  output logic                    m0_ack_o,
  output logic                    m0_err_o,
  output logic                    m0_rty_o,
  // master 1
  input  logic                    m1_cyc_i,
  input  logic                    m1_stb_i,
  input  logic                    m1_we_i,
  input  logic [ADDR_WIDTH-1:0]   m1_adr_i,
  input  logic [DATA_WIDTH-1:0]   m1_dat_i,
  input  logic [SELECT_WIDTH-1:0] m1_sel_i,
  output logic [DATA_WIDTH-1:0]   m1_dat_o,
  output logic                    m1_ack_o,
  output logic                    m1_err_o,
  output logic                    m1_rty_o,
  // shared slave
  output logic                    s_cyc_o,
  output logic                    s_stb_o,
  output logic                    s_we_o,
  output logic [ADDR_WIDTH-1:0]   s_adr_o,
  output logic [DATA_WIDTH-1:0]   s_dat_o,
  output logic [SELECT_WIDTH-1:0] s_sel_o,
  input  logic [DATA_WIDTH-1:0]   s_dat_i,
  input  logic                    s_ack_i,
  input  logic                    s_err_i,
  input  logic                    s_rty_i,
  // status
  output logic [1:0]              grant_o,
  output logic                    timeout_o
);

  localparam logic [15:0] c_TIMEOUT_LAST = 16'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_OWN0 = 2'd1,
    ST_OWN1 = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic        r_last_owner;   // 1 = m1 owned last, so m0 wins the next tie
  logic        w_last_owner_nxt;
  logic [15:0] r_tmo_cnt;
  logic [15:0] w_tmo_cnt_nxt;

  logic                    w_own0;
  logic                    w_own1;
  logic                    w_cyc;
  logic                    w_stb;
  logic                    w_resp;
  logic                    w_stall;
  logic                    w_timeout;

  assign w_own0 = (r_state == ST_OWN0);
  assign w_own1 = (r_state == ST_OWN1);

  // Request path: owner's signals pass straight through; zeros while idle.
  always_comb begin
    w_cyc   = 1'b0;
    w_stb   = 1'b0;
    s_we_o  = 1'b0;
    s_adr_o = '0;
    s_dat_o = '0;
    s_sel_o = '0;
    if (w_own0) begin
      w_cyc   = m0_cyc_i;
      w_stb   = m0_stb_i;
      s_we_o  = m0_we_i;
      s_adr_o = m0_adr_i;
      s_dat_o = m0_dat_i;
      s_sel_o = m0_sel_i;
    end else if (w_own1) begin
      w_cyc   = m1_cyc_i;
      w_stb   = m1_stb_i;
      s_we_o  = m1_we_i;
      s_adr_o = m1_adr_i;
      s_dat_o = m1_dat_i;
      s_sel_o = m1_sel_i;
    end
  end

  assign w_resp    = s_ack_i | s_err_i | s_rty_i;
  assign w_stall   = w_cyc & w_stb & ~w_resp;
  // A real slave response in the last allowed cycle beats the forced error.
  assign w_timeout = w_stall & (r_tmo_cnt == c_TIMEOUT_LAST);

  assign s_cyc_o   = w_cyc & ~w_timeout;
  assign s_stb_o   = w_stb & ~w_timeout;
  assign grant_o   = {w_own1, w_own0};
  assign timeout_o = w_timeout;

  assign m0_dat_o  = s_dat_i;
  assign m1_dat_o  = s_dat_i;
  assign m0_ack_o  = w_own0 & s_ack_i;
  assign m0_err_o  = w_own0 & (s_err_i | w_timeout);
  assign m0_rty_o  = w_own0 & s_rty_i;
  assign m1_ack_o  = w_own1 & s_ack_i;
  assign m1_err_o  = w_own1 & (s_err_i | w_timeout);
  assign m1_rty_o  = w_own1 & s_rty_i;

  always_comb begin
    w_state_nxt      = r_state;
    w_last_owner_nxt = r_last_owner;
    case (r_state)
      ST_IDLE: begin
        if (m0_cyc_i && m1_cyc_i) begin
          w_state_nxt = r_last_owner ? ST_OWN0 : ST_OWN1;
        end else if (m0_cyc_i) begin
          w_state_nxt = ST_OWN0;
        end else if (m1_cyc_i) begin
          w_state_nxt = ST_OWN1;
        end
      end
      ST_OWN0: begin
        if (!m0_cyc_i) begin
          w_state_nxt      = ST_IDLE;
          w_last_owner_nxt = 1'b0;
        end
      end
      ST_OWN1: begin
        if (!m1_cyc_i) begin
          w_state_nxt      = ST_IDLE;
          w_last_owner_nxt = 1'b1;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    w_tmo_cnt_nxt = r_tmo_cnt;
    if (!w_stall || w_timeout) begin
      w_tmo_cnt_nxt = '0;
    end else if (r_tmo_cnt != c_TIMEOUT_LAST) begin
      w_tmo_cnt_nxt = r_tmo_cnt + 16'd1;
    end
  end

  always_ff @(posedge wb_clk or negedge wb_rst_n) begin
    if (!wb_rst_n) begin
      r_state      <= ST_IDLE;
      r_last_owner <= 1'b1;
      r_tmo_cnt    <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_last_owner <= w_last_owner_nxt;
      r_tmo_cnt    <= w_tmo_cnt_nxt;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_wb_arbiter_2m.sv
//------------------------------------------------------------------------------
// tb_wb_arbiter_2m : directed self-checking bench for wb_arbiter_2m.
// Revision 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_wb_arbiter_2m;

  localparam int DW = 32;
  localparam int AW = 32;
  localparam int SW = 4;
  localparam int TO = 8;

  logic          wb_clk;
  logic          wb_rst_n;
  logic          m0_cyc_i, m0_stb_i, m0_we_i;
  logic [AW-1:0] m0_adr_i;
  logic [DW-1:0] m0_dat_i;
  logic [SW-1:0] m0_sel_i;
  logic [DW-1:0] m0_dat_o;
  logic          m0_ack_o, m0_err_o, m0_rty_o;
  logic          m1_cyc_i, m1_stb_i, m1_we_i;
  logic [AW-1:0] m1_adr_i;
  logic [DW-1:0] m1_dat_i;
  logic [SW-1:0] m1_sel_i;
  logic [DW-1:0] m1_dat_o;
  logic          m1_ack_o, m1_err_o, m1_rty_o;
  logic          s_cyc_o, s_stb_o, s_we_o;
  logic [AW-1:0] s_adr_o;
  logic [DW-1:0] s_dat_o;
  logic [SW-1:0] s_sel_o;
  logic [DW-1:0] s_dat_i;
  logic          s_ack_i, s_err_i, s_rty_i;
  logic [1:0]    grant_o;
  logic          timeout_o;

  int n_cmp = 0;
  int n_bad = 0;

  wb_arbiter_2m #(
    .DATA_WIDTH    (DW),
    .ADDR_WIDTH    (AW),
    .SELECT_WIDTH  (SW),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .wb_clk   (wb_clk),
    .wb_rst_n (wb_rst_n),
    .m0_cyc_i (m0_cyc_i),
    .m0_stb_i (m0_stb_i),
    .m0_we_i  (m0_we_i),
    .m0_adr_i (m0_adr_i),
    .m0_dat_i (m0_dat_i),
    .m0_sel_i (m0_sel_i),
    .m0_dat_o (m0_dat_o),
    .m0_ack_o (m0_ack_o),
    .m0_err_o (m0_err_o),
    .m0_rty_o (m0_rty_o),
    .m1_cyc_i (m1_cyc_i),
    .m1_stb_i (m1_stb_i),
    .m1_we_i  (m1_we_i),
    .m1_adr_i (m1_adr_i),
    .m1_dat_i (m1_dat_i),
    .m1_sel_i (m1_sel_i),
    .m1_dat_o (m1_dat_o),
    .m1_ack_o (m1_ack_o),
    .m1_err_o (m1_err_o),
    .m1_rty_o (m1_rty_o),
    .s_cyc_o  (s_cyc_o),
    .s_stb_o  (s_stb_o),
    .s_we_o   (s_we_o),
    .s_adr_o  (s_adr_o),
    .s_dat_o  (s_dat_o),
    .s_sel_o  (s_sel_o),
    .s_dat_i  (s_dat_i),
    .s_ack_i  (s_ack_i),
    .s_err_i  (s_err_i),
    .s_rty_i  (s_rty_i),
    .grant_o  (grant_o),
    .timeout_o(timeout_o)
  );

  initial begin
    wb_clk = 1'b0;
    forever #5 wb_clk = ~wb_clk;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step;
    @(posedge wb_clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [1:0] exp_g;
    wb_rst_n = 1'b0;
    {m0_cyc_i, m0_stb_i, m0_we_i, m1_cyc_i, m1_stb_i, m1_we_i} = '0;
    m0_adr_i = '0; m0_dat_i = '0; m0_sel_i = '0;
    m1_adr_i = '0; m1_dat_i = '0; m1_sel_i = '0;
    s_dat_i = '0; {s_ack_i, s_err_i, s_rty_i} = '0;

    // reset state
    #2;
    check("rst_grant", 32'(grant_o), 32'd0);
    check("rst_scyc", 32'(s_cyc_o), 32'd0);
    check("rst_sstb", 32'(s_stb_o), 32'd0);
    check("rst_tmo", 32'(timeout_o), 32'd0);
    check("rst_m0ack", 32'(m0_ack_o), 32'd0);
    #6 wb_rst_n = 1'b1;

    // single m0 read, ack on 3rd stb cycle
    step;
    m0_cyc_i = 1'b1; m0_stb_i = 1'b1; m0_adr_i = 32'h0000_0100; m0_sel_i = 4'hF;
    #1;
    check("rd_idle_grant", 32'(grant_o), 32'd0);
    check("rd_idle_scyc", 32'(s_cyc_o), 32'd0);
    step;
    check("rd_grant", 32'(grant_o), 32'd1);
    check("rd_scyc", 32'(s_cyc_o), 32'd1);
    check("rd_sadr", s_adr_o, 32'h0000_0100);
    step;
    step;
    s_ack_i = 1'b1; s_dat_i = 32'hDEAD_BEEF;
    #1;
    check("rd_m0ack", 32'(m0_ack_o), 32'd1);
    check("rd_m0dat", m0_dat_o, 32'hDEAD_BEEF);
    check("rd_m1ack", 32'(m1_ack_o), 32'd0);
    step;
    s_ack_i = 1'b0; m0_cyc_i = 1'b0; m0_stb_i = 1'b0;
    #1;
    check("rd_rel_scyc", 32'(s_cyc_o), 32'd0);
    check("rd_rel_grant", 32'(grant_o), 32'd1);
    step;
    check("rd_end_grant", 32'(grant_o), 32'd0);
    wb_rst_n = 1'b0;
    #1 wb_rst_n = 1'b1;

    // simultaneous requests alternate, m0 first after reset
    m0_cyc_i = 1'b1; m0_stb_i = 1'b1; m1_cyc_i = 1'b1; m1_stb_i = 1'b1;
    m1_adr_i = 32'h0000_0200;
    #1;
    check("alt_idle_sstb", 32'(s_stb_o), 32'd0);
    step;
    for (int i = 0; i < 8; i++) begin
      exp_g = (i % 2 == 0) ? 2'b01 : 2'b10;
      s_ack_i = 1'b1;
      #1;
      check("alt_grant", 32'(grant_o), 32'(exp_g));
      check("alt_m0ack", 32'(m0_ack_o), 32'(exp_g[0]));
      check("alt_m1ack", 32'(m1_ack_o), 32'(exp_g[1]));
      step;
      s_ack_i = 1'b0;
      if (exp_g[0]) begin m0_cyc_i = 1'b0; m0_stb_i = 1'b0; end
      else          begin m1_cyc_i = 1'b0; m1_stb_i = 1'b0; end
      #1;
      check("alt_rel_scyc", 32'(s_cyc_o), 32'd0);
      step;
      check("alt_idle_grant", 32'(grant_o), 32'd0);
      if (i < 6) begin
        if (exp_g[0]) begin m0_cyc_i = 1'b1; m0_stb_i = 1'b1; end
        else          begin m1_cyc_i = 1'b1; m1_stb_i = 1'b1; end
      end
      step;
    end

    // m1 holds a 3-beat cycle while m0 waits
    m1_cyc_i = 1'b1; m1_stb_i = 1'b1;
    step;
    m0_cyc_i = 1'b1; m0_stb_i = 1'b1;
    for (int b = 0; b < 3; b++) begin
      s_ack_i = 1'b1;
      #1;
      check("hold_grant", 32'(grant_o), 32'd2);
      check("hold_m1ack", 32'(m1_ack_o), 32'd1);
      check("hold_m0ack", 32'(m0_ack_o), 32'd0);
      step;
    end
    s_ack_i = 1'b0; m1_cyc_i = 1'b0; m1_stb_i = 1'b0;
    #1;
    check("hold_rel_grant", 32'(grant_o), 32'd2);
    step;
    check("hold_idle_grant", 32'(grant_o), 32'd0);
    step;
    check("hold_m0_grant", 32'(grant_o), 32'd1);

    // m0 now stalls: forced error on the 8th stalled cycle
    for (int k = 1; k < 8; k++) begin
      check("tmo_pre_pulse", 32'(timeout_o), 32'd0);
      check("tmo_pre_sstb", 32'(s_stb_o), 32'd1);
      step;
    end
    check("tmo_pulse", 32'(timeout_o), 32'd1);
    check("tmo_m0err", 32'(m0_err_o), 32'd1);
    check("tmo_sstb", 32'(s_stb_o), 32'd0);
    check("tmo_scyc", 32'(s_cyc_o), 32'd0);
    check("tmo_grant", 32'(grant_o), 32'd1);
    step;
    check("tmo_restart_pulse", 32'(timeout_o), 32'd0);
    check("tmo_restart_sstb", 32'(s_stb_o), 32'd1);
    check("tmo_restart_err", 32'(m0_err_o), 32'd0);
    // ack arriving exactly in the 8th stalled cycle wins
    repeat (7) step;
    s_ack_i = 1'b1;
    #1;
    check("race_m0ack", 32'(m0_ack_o), 32'd1);
    check("race_m0err", 32'(m0_err_o), 32'd0);
    check("race_tmo", 32'(timeout_o), 32'd0);
    step;
    s_ack_i = 1'b0; m0_cyc_i = 1'b0; m0_stb_i = 1'b0;
    step;
    check("race_end_grant", 32'(grant_o), 32'd0);

    // asynchronous reset in the middle of an m1 burst
    m1_cyc_i = 1'b1; m1_stb_i = 1'b1;
    step;
    s_ack_i = 1'b1;
    #1;
    check("arst_pre_grant", 32'(grant_o), 32'd2);
    #1 wb_rst_n = 1'b0;
    #1;
    check("arst_grant", 32'(grant_o), 32'd0);
    check("arst_scyc", 32'(s_cyc_o), 32'd0);
    check("arst_m1ack", 32'(m1_ack_o), 32'd0);
    #1 wb_rst_n = 1'b1;
    s_ack_i = 1'b0; m0_cyc_i = 1'b1; m0_stb_i = 1'b1;
    step;
    check("arst_first_grant", 32'(grant_o), 32'd1);

    {m0_cyc_i, m0_stb_i, m1_cyc_i, m1_stb_i} = '0;
    step;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/wb_arbiter_2m.md
WB_ARBITER_2M -- requirements
Module: wb_arbiter_2m

Interface
REQ-001 Parameter DATA_WIDTH, default 32, data bus width for both masters and the slave.
REQ-002 Parameter ADDR_WIDTH, default 32, byte address width.
REQ-003 Parameter SELECT_WIDTH, default 4, byte-select width; equals DATA_WIDTH/8.
REQ-004 Parameter TIMEOUT_CYCLES, default 1023, number of stalled cycles before a bus error is forced; range 2..65535.
REQ-005 Clocking and reset are fixed: one clock, and reset is asynchronous and active-low.
REQ-006 Port wb_clk, input, 1, sole clock; all state updates on its rising edge.
REQ-007 Port wb_rst_n, input, 1, asynchronous active-low reset.
REQ-008 Ports m0_cyc_i, m0_stb_i, m0_we_i, input, 1 each, master-0 Wishbone classic controls.
REQ-009 Ports m0_adr_i (ADDR_WIDTH), m0_dat_i (DATA_WIDTH), m0_sel_i (SELECT_WIDTH), input, master-0 address, write data and byte selects.
REQ-010 Ports m0_dat_o (DATA_WIDTH), m0_ack_o, m0_err_o, m0_rty_o (1 each), output, master-0 response.
REQ-011 Ports m1_* are identical in name pattern, direction and width to REQ-008..REQ-010 and serve master 1.
REQ-012 Ports s_cyc_o, s_stb_o, s_we_o (1), s_adr_o, s_dat_o, s_sel_o, output, shared slave request.
REQ-013 Ports s_dat_i (DATA_WIDTH), s_ack_i, s_err_i, s_rty_i (1 each), input, slave response.
REQ-014 Port grant_o, output, 2, one-hot current owner: bit0 = m0, bit1 = m1, 00 = idle.
REQ-015 Port timeout_o, output, 1, single-cycle pulse on a forced timeout.

Function
REQ-016 FSM states: IDLE, OWN0, OWN1; grant_o is 01 in OWN0, 10 in OWN1, and 00 in IDLE.
REQ-017 IDLE with only mX_cyc_i high: next state is OWNX.
REQ-018 IDLE with both cyc high: grant the master not granted last; the last-owner register resets to 1, so m0 wins first.
REQ-019 Arbitration latency: the request is sampled in IDLE and the grant is visible on the next cycle.
REQ-020 In OWNX, s_cyc_o, s_stb_o, s_we_o, s_adr_o, s_dat_o and s_sel_o combinationally follow master X.
REQ-021 In IDLE, s_cyc_o and s_stb_o are 0 and the other slave outputs are don't-care, driven to 0.
REQ-022 In IDLE, slave cyc/stb are not driven even when cyc is pending.
REQ-023 Ownership is held while the owner's cyc is high, so a multi-beat cycle is never split.
REQ-024 A request from the non-owner is held off until the owner's cycle ends.
REQ-025 When the owner drops cyc: s_cyc_o drops in the same cycle, the FSM goes to IDLE on the next edge, last-owner is updated, and the timeout counter clears.
REQ-026 After release the FSM always spends at least one IDLE cycle; back-to-back alternation is OWN0, IDLE, OWN1.
REQ-027 mX_ack_o, err_o and rty_o equal the slave response gated by grant_o[X]; the non-owner always sees 0.
REQ-028 m0_dat_o and m1_dat_o both equal s_dat_i, ungated.
REQ-029 Timeout counter: 16 bit; increments each cycle in OWNX while s_stb_o=1 and s_ack_i, s_err_i and s_rty_i are all 0.
REQ-030 The timeout counter clears on any slave response, on stb low, or in IDLE.
REQ-031 When the counter equals TIMEOUT_CYCLES-1 and the slave still gives no response, for that one cycle:
  - mX_err_o=1, timeout_o=1, s_cyc_o=0, s_stb_o=0;
  - the counter clears and the FSM stays in OWNX.
REQ-032 If a slave ack/err/rty arrives in the timeout cycle, the slave response wins: no forced err and no timeout_o.
REQ-033 The counter saturates at TIMEOUT_CYCLES-1; it never wraps.

Reset
REQ-034 While wb_rst_n=0: FSM=IDLE, grant_o=00, timeout_o=0, counter=0, last-owner=1, all s_cyc_o/s_stb_o and master ack/err/rty outputs 0.
REQ-035 Reset asserted mid-transaction aborts it immediately (asynchronous); no response is owed to the master.
REQ-036 After reset deassertion the first arbitration follows REQ-018.

Verification
REQ-037 m0 single read, slave acks on 3rd stb cycle with 0xDEADBEEF -> grant_o=01 one cycle after cyc, m0_ack_o pulse, m0_dat_o=0xDEADBEEF, then grant_o=00.
REQ-038 m0 and m1 raise cyc in the same cycle, each doing 4 one-beat cycles -> grants alternate 01,00,10,00,01... starting with m0; m1 never sees ack during m0 ownership.
REQ-039 m1 owns, holds cyc for 3 acked beats while m0 requests -> m0 waits, grant_o stays 10 across all beats, m0 granted 2 cycles after m1 drops cyc.
REQ-040 TIMEOUT_CYCLES=8, slave never responds -> after 8 stb cycles m0_err_o=1, timeout_o=1 for one cycle, s_stb_o=0 that cycle, counter restarts.
REQ-041 TIMEOUT_CYCLES=8, slave acks exactly in the 8th stalled cycle -> m0_ack_o=1, m0_err_o=0, timeout_o=0.
REQ-042 wb_rst_n pulsed low during an m1 burst -> grant_o=00 and s_cyc_o=0 asynchronously; the next simultaneous request grants m0.
